// File: rtl/hrange_consumer.sv
// hrange_consumer: starts one hrange child per request, sums and counts its yields, holds the result for the parent.
// Optional HRANGE_CONSUMER_SAT_EN: clamp the sum on signed overflow instead of wrapping.
module hrange_consumer #(
  parameter int TIMEOUT = 1024
) (
  input  logic               _clock,
  input  logic               _reset,
  input  logic signed [31:0] base,
  input  logic signed [31:0] limit,
  input  logic signed [31:0] step,
  input  logic               _start,
  input  logic               _wait,
  output logic signed [31:0] _0,
  output logic        [31:0] _1,
  output logic               _ovf,
  output logic               _err,
  output logic               _ready,
  output logic               _valid,
  output logic signed [31:0] c_base,
  output logic signed [31:0] c_limit,
  output logic signed [31:0] c_step,
  output logic               c_start,
  output logic               c_wait,
  input  logic signed [31:0] c_0,
  input  logic               c_valid,
  input  logic               c_ready
);

  typedef enum logic [1:0] {IDLE, CALL, COLLECT, RESULT} state_t;

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  state_t             state;
  logic        [31:0] idle_cnt;
  logic        [31:0] idle_inc;
  logic signed [31:0] add_res;
  logic signed [31:0] sum_next;
  logic               add_ovf;

  assign c_wait   = 1'b0;
  assign idle_inc = idle_cnt + 32'd1;

  always_comb begin
    add_res  = _0 + c_0;
    add_ovf  = (_0[31] == c_0[31]) && (add_res[31] != _0[31]);
    sum_next = add_res;
`ifdef HRANGE_CONSUMER_SAT_EN
    // Clamp toward the sign both addends share.
    if (add_ovf) sum_next = _0[31] ? {1'b1, 31'd0} : {1'b0, {31{1'b1}}};
`endif
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state    <= IDLE;
      idle_cnt <= '0;
      _0       <= '0;
      _1       <= '0;
      _ovf     <= 1'b0;
      _err     <= 1'b0;
      _ready   <= 1'b1;
      _valid   <= 1'b0;
      c_base   <= '0;
      c_limit  <= '0;
      c_step   <= '0;
      c_start  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (_start) begin
            c_base   <= base;
            c_limit  <= limit;
            c_step   <= step;
            _0       <= '0;
            _1       <= '0;
            _ovf     <= 1'b0;
            _err     <= 1'b0;
            idle_cnt <= '0;
            _ready   <= 1'b0;
            c_start  <= 1'b1;
            state    <= CALL;
          end
        end
        CALL: begin
          c_start <= 1'b0;
          state   <= COLLECT;
        end
        COLLECT: begin
          if (c_valid) begin
            _0       <= sum_next;
            _1       <= _1 + 32'd1;
            idle_cnt <= '0;
            if (add_ovf) _ovf <= 1'b1;
          end
          // A final value arriving with c_ready is accumulated above before leaving.
          if (c_ready) begin
            _valid <= 1'b1;
            state  <= RESULT;
          end else if (!c_valid) begin
            if ((TIMEOUT != 0) && (idle_inc == TIMEOUT_W)) begin
              _err   <= 1'b1;
              _valid <= 1'b1;
              state  <= RESULT;
            end else begin
              idle_cnt <= idle_inc;
            end
          end
        end
        RESULT: begin
          if (!_wait) begin
            _valid <= 1'b0;
            _ready <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hrange_consumer.sv
// Bench for hrange_consumer: scripted child stub, behavioural result model, directed plus random requests.
module tb_hrange_consumer;

  localparam int TO = 8;

  typedef struct packed {
    logic        v;
    logic        r;
    logic [31:0] d;
  } beat_t;

  logic               clk;
  logic               rst;
  logic signed [31:0] base, limit, step;
  logic               start, wait_h;
  logic signed [31:0] r_sum;
  logic        [31:0] r_cnt;
  logic               r_ovf, r_err, r_ready, r_valid;
  logic signed [31:0] c_base, c_limit, c_step;
  logic               c_start, c_wait;
  logic signed [31:0] c_0;
  logic               c_valid, c_ready;

  hrange_consumer #(.TIMEOUT(TO)) dut (
    ._clock(clk), ._reset(rst),
    .base(base), .limit(limit), .step(step),
    ._start(start), ._wait(wait_h),
    ._0(r_sum), ._1(r_cnt), ._ovf(r_ovf), ._err(r_err),
    ._ready(r_ready), ._valid(r_valid),
    .c_base(c_base), .c_limit(c_limit), .c_step(c_step),
    .c_start(c_start), .c_wait(c_wait),
    .c_0(c_0), .c_valid(c_valid), .c_ready(c_ready)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int n_req  = 0;

  beat_t       script[$];
  beat_t       cq[$];
  logic        cs_seen = 1'b0;
  logic [31:0] exp_sum, exp_cnt, exp_base, exp_limit, exp_step;
  logic        exp_ovf, exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected result of consuming the current script: 64-bit range test for overflow.
  function automatic void model(output logic [31:0] sum, output logic [31:0] cnt,
                                output logic ovf, output logic err, output int lat);
    longint t;
    int     idle;
    beat_t  b;
    sum = '0; cnt = '0; ovf = 1'b0; err = 1'b0; lat = -1; idle = 0;
    for (int i = 0; i < 1000; i++) begin
      b = (i < script.size()) ? script[i] : '0;
      if (b.v) begin
        t = longint'($signed(sum)) + longint'($signed(b.d));
        if (t > 64'sh7FFFFFFF || t < -64'sh80000000) begin
          ovf = 1'b1;
`ifdef HRANGE_CONSUMER_SAT_EN
          sum = (t > 0) ? 32'h7FFFFFFF : 32'h80000000;
`else
          sum = t[31:0];
`endif
        end else begin
          sum = t[31:0];
        end
        cnt  = cnt + 32'd1;
        idle = 0;
      end
      if (b.r) begin
        lat = i + 2;
        return;
      end
      if (!b.v) begin
        idle++;
        if (idle == TO) begin
          err = 1'b1;
          lat = i + 2;
          return;
        end
      end
    end
  endfunction

  // hrange-like child: yields base, base+step, ... below limit, then finishes.
  function automatic void make_range(input longint b, input longint l, input longint s,
                                     input int gap_pct, input logic merge);
    longint x;
    beat_t  bt;
    script.delete();
    x = b;
    while (x < l) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) script.push_back(beat_t'({1'b0, 1'b0, 32'd0}));
      script.push_back(beat_t'({1'b1, 1'b0, x[31:0]}));
      x = x + s;
    end
    if (merge && script.size() > 0) begin
      bt = script.pop_back();
      bt.r = 1'b1;
      script.push_back(bt);
    end else begin
      script.push_back(beat_t'({1'b0, 1'b1, 32'd0}));
    end
  endfunction

  task automatic pin(input string tag, input logic [31:0] es, input logic [31:0] ec,
                     input logic eo, input logic ee, input int el);
    logic [31:0] s, c;
    logic        o, e;
    int          l;
    model(s, c, o, e, l);
    check({tag, "_model_sum"}, s, es);
    check({tag, "_model_cnt"}, c, ec);
    check({tag, "_model_ovf"}, {31'd0, o}, {31'd0, eo});
    check({tag, "_model_err"}, {31'd0, e}, {31'd0, ee});
    check({tag, "_model_lat"}, 32'(l), 32'(el));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sum"}, r_sum, 32'd0);
    check({tag, "_cnt"}, r_cnt, 32'd0);
    check({tag, "_flags"}, {28'd0, r_ovf, r_err, r_valid, c_start}, 32'd0);
    check({tag, "_ready"}, {31'd0, r_ready}, 32'd1);
    check({tag, "_cwait"}, {31'd0, c_wait}, 32'd0);
    check({tag, "_cargs"}, c_base | c_limit | c_step, 32'd0);
  endtask

  task automatic issue(input logic [31:0] b, input logic [31:0] l, input logic [31:0] s);
    exp_base = b; exp_limit = l; exp_step = s;
    base = b; limit = l; step = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_req++;
  endtask

  task automatic run_txn(input logic [31:0] b, input logic [31:0] l, input logic [31:0] s, input int w);
    int lat_exp;
    int cyc;
    model(exp_sum, exp_cnt, exp_ovf, exp_err, lat_exp);
    check("ready_before", {31'd0, r_ready}, 32'd1);
    issue(b, l, s);
    cyc = 0;
    while (!r_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat_exp));
    if (!r_valid) return;
    wait_h = (w > 0);
    for (int j = 1; j <= w; j++) begin
      @(negedge clk);
      start = (j == 1 && w >= 2);
      if (j == w) wait_h = 1'b0;
      check("held_valid", {31'd0, r_valid}, 32'd1);
    end
    start = 1'b0;
    @(negedge clk);
    check("valid_drop", {31'd0, r_valid}, 32'd0);
    check("ready_back", {31'd0, r_ready}, 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(negedge clk);
    cs_seen = c_start;
  end

  // Child stub: replays the script one beat per cycle starting the edge after c_start.
  initial begin
    beat_t b;
    c_valid = 1'b0; c_ready = 1'b0; c_0 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) cq.delete();
      else if (cs_seen) cq = script;
      if (!rst && cq.size() > 0) begin
        b = cq.pop_front();
        c_valid = b.v; c_ready = b.r; c_0 = b.d;
      end else begin
        c_valid = 1'b0; c_ready = 1'b0; c_0 = '0;
      end
    end
  end

  // Result and child-argument compare on every meaningful cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (r_valid) begin
        check("sum", r_sum, exp_sum);
        check("count", r_cnt, exp_cnt);
        check("ovf", {31'd0, r_ovf}, {31'd0, exp_ovf});
        check("err", {31'd0, r_err}, {31'd0, exp_err});
      end
      if (c_start) begin
        starts++;
        check("c_base", c_base, exp_base);
        check("c_limit", c_limit, exp_limit);
        check("c_step", c_step, exp_step);
      end
    end
  end

  initial begin
    int n;
    int w;
    rst = 1'b1; start = 1'b0; wait_h = 1'b0;
    base = '0; limit = '0; step = '0;
    exp_sum = '0; exp_cnt = '0; exp_ovf = 1'b0; exp_err = 1'b0;
    exp_base = '0; exp_limit = '0; exp_step = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    make_range(0, 5, 1, 0, 1'b0);
    pin("r05", 32'd10, 32'd5, 1'b0, 1'b0, 7);
    run_txn(0, 5, 1, 0);

    make_range(3, 3, 1, 0, 1'b0);
    pin("empty", 32'd0, 32'd0, 1'b0, 1'b0, 2);
    run_txn(3, 3, 1, 0);

    make_range(0, 10, 3, 0, 1'b0);
    pin("r0103", 32'd18, 32'd4, 1'b0, 1'b0, 6);
    run_txn(0, 10, 3, 4);

    script.delete();
    script.push_back(beat_t'({1'b1, 1'b0, 32'h7FFFFFF0}));
    script.push_back(beat_t'({1'b1, 1'b0, 32'h00000020}));
    script.push_back(beat_t'({1'b0, 1'b1, 32'd0}));
`ifdef HRANGE_CONSUMER_SAT_EN
    pin("ovf", 32'h7FFFFFFF, 32'd2, 1'b1, 1'b0, 4);
`else
    pin("ovf", 32'h80000010, 32'd2, 1'b1, 1'b0, 4);
`endif
    run_txn(32'd7, 32'd8, 32'd9, 1);

    script.delete();
    script.push_back(beat_t'({1'b1, 1'b0, 32'd2}));
    pin("tmo", 32'd2, 32'd1, 1'b0, 1'b1, 10);
    run_txn(32'd1, 32'd2, 32'd3, 0);

    make_range(0, 5, 1, 0, 1'b0);
    model(exp_sum, exp_cnt, exp_ovf, exp_err, n);
    issue(0, 5, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("postreset");
    run_txn(0, 5, 1, 0);

    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) begin
        make_range(longint'($urandom_range(0, 200)) - 100, longint'($urandom_range(0, 200)) - 50,
                   longint'($urandom_range(1, 20)), 30, 1'($urandom_range(1)));
      end else begin
        script.delete();
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++) begin
          repeat ($urandom_range(0, 2)) script.push_back(beat_t'({1'b0, 1'b0, 32'd0}));
          if ($urandom_range(9) == 0) repeat ($urandom_range(6, 10)) script.push_back(beat_t'({1'b0, 1'b0, 32'd0}));
          if ($urandom_range(3) == 0) script.push_back(beat_t'({1'b1, 1'b0, $urandom()}));
          else script.push_back(beat_t'({1'b1, 1'b0, 32'($urandom_range(0, 2000)) - 32'd1000}));
        end
        if ($urandom_range(4) != 0) script.push_back(beat_t'({1'b0, 1'b1, 32'd0}));
      end
      w = $urandom_range(0, 3);
      run_txn($urandom(), $urandom(), $urandom(), w);
    end

    repeat (3) @(negedge clk);
    check("start_count", 32'(starts), 32'(n_req));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hrange_consumer.md
# hrange_consumer

Caller side of the generator function-call protocol: accepts a `(base, limit, step)` request from its parent, issues one `c_start` to a child `hrange` generator, and consumes every yielded value. It accumulates a signed sum and a count, then presents both to the parent as one held result. It sits between a parent FSM and an `hrange` instance and is the template for generated caller logic.

## Interface
Parameters:
- `TIMEOUT`, default 1024: max idle cycles in COLLECT with neither `c_valid` nor `c_ready` before abort; 0 disables the timeout.

Ports:
- `_clock` in 1: single clock, all logic on its rising edge.
- `_reset` in 1: asynchronous, active-high reset.
- `base`, `limit`, `step` in 32 signed: request arguments, sampled with `_start`.
- `_start` in 1: request strobe, honoured only while `_ready`=1.
- `_wait` in 1: parent backpressure; result held while high.
- `_0` out 32 signed: sum of consumed values.
- `_1` out 32 unsigned: number of consumed values.
- `_ovf` out 1: sticky signed-overflow flag for the current result.
- `_err` out 1: result was cut short by timeout.
- `_ready` out 1: idle, able to accept `_start`.
- `_valid` out 1: result valid on `_0`, `_1`, `_ovf`, `_err`.
- `c_base`, `c_limit`, `c_step` out 32 signed: child arguments.
- `c_start` out 1: child start strobe.
- `c_wait` out 1: tied 0; every child beat is accepted.
- `c_0` in 32 signed: child yielded value.
- `c_valid` in 1: `c_0` valid this cycle.
- `c_ready` in 1: child finished (one-cycle pulse).

## Operation
- States: IDLE, CALL, COLLECT, RESULT.
- IDLE: `_ready`=1.
  - On `_start`, register the arguments into `c_*`, clear sum, count, `_ovf`, `_err` and the timeout counter, then go to CALL.
- CALL: one cycle only. `c_start`=1, then go to COLLECT.
- COLLECT, per cycle:
  - If `c_valid`: sum += `c_0`, count += 1, and the timeout counter is cleared.
  - If `c_ready`: go to RESULT. If `c_valid` and `c_ready` arrive in the same cycle, the value is accumulated first.
  - If neither is present: the timeout counter increments. When it reaches `TIMEOUT` (and `TIMEOUT` is not 0), set `_err`=1 and go to RESULT.
  - Values arriving outside COLLECT are ignored.
- RESULT: `_valid`=1 and the outputs are stable.
  - On an edge with `_wait`=0, the result is consumed and the block returns to IDLE.
- Arithmetic:
  - Sum is 32-bit signed. Overflow is detected when the two addend signs match and the sign of the result differs; this sets `_ovf`, which stays set until the next `_start`.
  - Count is 32-bit and wraps without a flag.
- `_start` while busy (`_ready`=0) is ignored and is never queued.
- Reset, including mid-operation:
  - All state is cleared immediately to IDLE.
  - `_0`, `_1`, `_ovf`, `_err`, `_valid`, `c_start`, `c_wait`, and `c_base`/`c_limit`/`c_step` are 0; `_ready`=1 after reset.
  - The child is not notified; the parent must also reset the child.

## Timing
- `_start` is sampled at edge E0. `c_start` is high for the single cycle after E0.
- Against the `hrange` child, a range of N values gives:
  - yields visible after E1..EN;
  - `c_ready` visible after E(N+1);
  - `_valid` high after E(N+2).
- The latency is N+2 cycles from E0 to `_valid`. An empty range (N=0) gives 2 cycles.
- `_valid` stays high for exactly as many cycles as `_wait` holds it, with a minimum of 1.
- `_ready` rises in the cycle after the consuming edge. Back-to-back requests are therefore spaced at least N+4 cycles apart.
- Timeout abort: `_valid` is high after the edge at which the idle count equals `TIMEOUT`.

## Configuration
- `HRANGE_CONSUMER_SAT_EN` defined: on overflow the sum clamps to 32'h7FFFFFFF (positive) or 32'h80000000 (negative).
  - Once clamped, further accumulation continues from the clamped value.
  - `_ovf` is set.
- Undefined: the sum wraps two's-complement, and `_ovf` is still set.

## Test plan
- Request `base=0, limit=5, step=1` with the real `hrange` child -> `_0`=10, `_1`=5, `_ovf`=0, `_err`=0, `_valid` high 7 cycles after the `_start` edge.
- Request `base=3, limit=3, step=1` (empty range) -> `_0`=0, `_1`=0, `_valid` 2 cycles after start.
- Request `base=0, limit=10, step=3`, then hold `_wait`=1 for 4 cycles -> `_0`=18, `_1`=4, values unchanged while held. A `_start` pulsed during the hold is ignored. `_ready` returns one cycle after `_wait` falls.
- Stub child yields 32'h7FFFFFF0 then 32'h00000020 -> `_ovf`=1.
  - With `HRANGE_CONSUMER_SAT_EN`: `_0`=32'h7FFFFFFF.
  - Without it: `_0`=32'h80000010.
- `TIMEOUT`=8, stub child yields 2 then goes silent -> `_err`=1, `_0`=2, `_1`=1, `_valid` after the 8th idle edge.
- Assert `_reset` for 1 cycle while in COLLECT -> `_valid`=0, `_ready`=1, outputs 0 immediately. A new request then completes normally with `_0`=10 for `0..5`.
